// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator/receiver pair.
// Both ends agree on duty resolution, window length and the stall timeout default.
package pwm_pkg;

    localparam int PWM_WIDTH   = 8;
    localparam int PWM_WIN_LEN = 1 << PWM_WIDTH;
    localparam int PWM_TIMEOUT = 64;

endpackage

// File: rtl/pwm_sync.sv
// Multi-flop synchroniser for an asynchronous level, with a rising-edge strobe.
// The strobe is one clk cycle wide and derived from the synchronised level.
module pwm_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pwm_in.sv
// PWM receiver: counts high samples over a 2^WIDTH-tick window of pwm_clk and reports duty.
// Optional PWM_IN_STABLE_EN: commit a window only when it matches the previous raw window.
module pwm_in
    import pwm_pkg::*;
#(
    parameter int WIDTH       = PWM_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = PWM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_clk,
    input  logic             pwm,
    output logic [WIDTH-1:0] duty,
    output logic             valid,
    output logic             stalled
);

    localparam int              TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [WIDTH-1:0] WIN_LAST = '1;

    logic             tick;
    logic             smp;
    logic             unused_clk_lvl;
    logic             unused_pwm_rise;
    logic [TO_W-1:0]  to_cnt;
    logic [WIDTH-1:0] win_cnt;
    logic [WIDTH:0]   hi_cnt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res;
    logic             win_end;
    logic             commit;

    pwm_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
        .clk  (clk),
        .rst  (rst),
        .d    (pwm_clk),
        .q    (unused_clk_lvl),
        .rise (tick)
    );

    pwm_sync #(.STAGES(SYNC_STAGES)) u_sync_pwm (
        .clk  (clk),
        .rst  (rst),
        .d    (pwm),
        .q    (smp),
        .rise (unused_pwm_rise)
    );

    assign stalled = (to_cnt == TO_MAX);
    assign win_end = tick && (win_cnt == WIN_LAST);
    assign sum     = hi_cnt + (WIDTH+1)'(smp);
    // A constant-high input yields 2^WIDTH samples, which does not fit in duty.
    assign res     = sum[WIDTH] ? '1 : sum[WIDTH-1:0];

`ifdef PWM_IN_STABLE_EN
    logic [WIDTH-1:0] raw_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_q <= '0;
        end else if (win_end) begin
            raw_q <= res;
        end else if (stalled) begin
            raw_q <= '0;
        end
    end

    assign commit = win_end && (res == raw_q);
`else
    assign commit = win_end;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt  <= '0;
            win_cnt <= '0;
            hi_cnt  <= '0;
        end else if (tick) begin
            to_cnt  <= '0;
            win_cnt <= win_cnt + 1'b1;
            hi_cnt  <= win_end ? '0 : sum;
        end else if (!stalled) begin
            to_cnt  <= to_cnt + 1'b1;
        end else begin
            // Without ticks the partial window is meaningless; restart from scratch.
            win_cnt <= '0;
            hi_cnt  <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            duty  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= commit;
            if (commit) begin
                duty <= res;
            end
        end
    end

endmodule

// File: tb/tb_pwm_in.sv
// Bench for pwm_in: behavioural PWM source, window-sum reference model and a scoreboard monitor.
module tb_pwm_in;
    import pwm_pkg::*;

    localparam int WIN = PWM_WIN_LEN;

    logic       clk = 1'b0;
    logic       rst;
    logic       pwm_clk;
    logic       pwm;
    logic [7:0] duty;
    logic       valid;
    logic       stalled;

    always #10 clk = ~clk;

    pwm_in dut (
        .clk     (clk),
        .rst     (rst),
        .pwm_clk (pwm_clk),
        .pwm     (pwm),
        .duty    (duty),
        .valid   (valid),
        .stalled (stalled)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    int win_n, hi_n, prev_raw, last_commit;
    int gen_phase, gen_duty, gen_next;
    int mon_vcnt = 0;
    logic valid_d = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: every 2^WIDTH sampled ticks, the number of high samples (capped at 255).
    task automatic model_tick(input int s);
        int raw;
        hi_n += s;
        win_n++;
        if (win_n == WIN) begin
            raw = (hi_n > 255) ? 255 : hi_n;
`ifdef PWM_IN_STABLE_EN
            if (raw == prev_raw) begin
                exp_q.push_back(8'(raw));
                last_commit = raw;
            end
            prev_raw = raw;
`else
            exp_q.push_back(8'(raw));
            last_commit = raw;
`endif
            win_n = 0;
            hi_n  = 0;
        end
    endtask

    task automatic model_restart();
        win_n    = 0;
        hi_n     = 0;
        prev_raw = 0;
    endtask

    task automatic set_duty(input int d, input bit immediate);
        gen_next = d;
        if (immediate) begin
            gen_duty = d;
            pwm = (gen_phase < gen_duty);
        end
    endtask

    // pwm changes on the falling pwm_clk edge, so it is stable when the rising edge is sampled.
    task automatic do_tick();
        pwm_clk = 1'b1;
        model_tick(int'(pwm));
        #50;
        gen_phase = (gen_phase + 1) % WIN;
        if (gen_phase == 0) gen_duty = gen_next;
        pwm = (gen_phase < gen_duty);
        pwm_clk = 1'b0;
        #50;
    endtask

    task automatic ticks(input int n);
        @(negedge clk);
        #3;
        for (int i = 0; i < n; i++) do_tick();
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        wait_clk(5);
        check("pending_before_rst", exp_q.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_duty", int'(duty), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_stalled", int'(stalled), 0);
        @(negedge clk);
        rst = 1'b0;
        model_restart();
        last_commit = 0;
    endtask

    always @(negedge clk) begin
        if (valid) begin
            mon_vcnt++;
            check("valid_one_cycle", int'(valid_d), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_valid: got duty %0d expected no valid", duty);
            end else begin
                check("duty", int'(duty), int'(exp_q.pop_front()));
            end
        end
        valid_d = valid;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0;
        int d;
        int dlist[8];

        rst       = 1'b1;
        pwm_clk   = 1'b0;
        gen_phase = 0;
        gen_duty  = 100;
        gen_next  = 100;
        pwm       = 1'b1;
        model_restart();
        last_commit = 0;
        wait_clk(3);
        check("init_duty", int'(duty), 0);
        check("init_valid", int'(valid), 0);
        check("init_stalled", int'(stalled), 0);
        rst = 1'b0;

        // Mid-window reset, then duty 100; first valid exactly 256 ticks after release.
        ticks(100);
        do_reset();
        v0 = mon_vcnt;
        ticks(WIN - 1);
        wait_clk(10);
`ifndef PWM_IN_STABLE_EN
        check("no_valid_before_256", mon_vcnt - v0, 0);
`endif
        ticks(1);
        wait_clk(10);
`ifndef PWM_IN_STABLE_EN
        check("valid_at_256", mon_vcnt - v0, 1);
`endif
        ticks(2 * WIN);

        // Duty sweep with boundary values and random points; updates land at period wrap.
        dlist[0] = 0;
        dlist[1] = 1;
        dlist[2] = 255;
        dlist[3] = 254;
        for (int i = 4; i < 8; i++) dlist[i] = int'($urandom_range(0, 255));
        for (int i = 0; i < 8; i++) begin
            set_duty(dlist[i], 1'b0);
            ticks(WIN * 5 / 2);
        end

        // Constant high saturates, constant low reads zero.
        set_duty(WIN, 1'b1);
        ticks(3 * WIN);
        wait_clk(10);
        check("sat_high", int'(duty), 255);
        set_duty(0, 1'b1);
        ticks(3 * WIN);
        wait_clk(10);
        check("held_low", int'(duty), 0);

        // Stall and restart with duty 37.
        d = 37;
        set_duty(d, 1'b1);
        ticks(3 * WIN);
        wait_clk(55);
        check("stalled_early", int'(stalled), 0);
        wait_clk(15);
        check("stalled_at_timeout", int'(stalled), 1);
        model_restart();
        wait_clk(30);
        check("stalled_hold", int'(stalled), 1);
        check("duty_hold_stall", int'(duty), last_commit);
        check("duty_hold_37", int'(duty), d);
        v0 = mon_vcnt;
        ticks(1);
        check("stall_clear_tick", int'(stalled), 0);
        ticks(WIN - 2);
        wait_clk(10);
`ifndef PWM_IN_STABLE_EN
        check("restart_no_early_valid", mon_vcnt - v0, 0);
`endif
        ticks(1);
        wait_clk(10);
`ifndef PWM_IN_STABLE_EN
        check("restart_valid_256", mon_vcnt - v0, 1);
        check("restart_duty", int'(duty), d);
`endif
        ticks(2 * WIN);

        // Reset while stalled clears everything.
        wait_clk(100);
        check("stalled_before_rst", int'(stalled), 1);
        check("duty_before_rst", int'(duty), d);
        do_reset();

        wait_clk(20);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_in.md
Name: pwm_in

Overview:
- PWM receiver/decoder: recovers the 8-bit duty value from a PWM waveform produced by the team's PWM generator on the far side of a link.
- Counts high samples over a 2^WIDTH-tick window of the shared pwm_clk and reports the duty value with a one-cycle valid strobe.
- Sits in the clk domain; pwm_clk and pwm are asynchronous inputs, synchronised internally.

Parameters:
- WIDTH, 8, duty resolution in bits; the window is 2^WIDTH pwm_clk ticks.
- SYNC_STAGES, 2, flip-flop synchroniser depth. Applied identically to pwm_clk and pwm.
- TIMEOUT, 64, clk cycles without a pwm_clk tick before stalled asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- pwm_clk  in  1  PWM tick clock, asynchronous, sampled
- pwm  in  1  PWM waveform, asynchronous, sampled
- duty  out  WIDTH  last measured duty
- valid  out  1  one-cycle strobe when duty updates
- stalled  out  1  pwm_clk absent for TIMEOUT cycles

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
  - rst is sampled on the rising clk edge.
- Reset values:
  - duty = 0, valid = 0, stalled = 0.
  - All synchroniser flops = 0; win_cnt = 0, hi_cnt = 0, to_cnt = 0.
- Synchronisation:
  - pwm_clk and pwm each pass through SYNC_STAGES flops.
  - tick = synced pwm_clk rising edge (current 1, previous 0); tick lasts one clk cycle.
  - smp = synced pwm in the tick cycle.
  - Requirement: pwm_clk period must be at least 4 clk periods.
- Window counting:
  - win_cnt (WIDTH bits) increments on every tick and wraps at 2^WIDTH-1 to 0.
  - hi_cnt (WIDTH+1 bits) adds smp on every tick.
  - The window needs no alignment to the PWM period. Because the input is periodic with period 2^WIDTH ticks, any window contains exactly duty high samples.
- Window end (tick with win_cnt == 2^WIDTH-1):
  - sum = hi_cnt + smp.
  - duty <= sum, saturated to 2^WIDTH-1 when sum == 2^WIDTH (constant-high input).
  - hi_cnt <= 0.
  - valid = 1 in the following cycle only.
  - Latency: duty and valid are registered one clk after the final tick.
- Timeout:
  - to_cnt counts clk cycles, clears on tick and saturates at TIMEOUT.
  - When to_cnt reaches TIMEOUT: stalled = 1, win_cnt and hi_cnt clear, duty holds its last value.
  - The next tick clears stalled in the same cycle the count resumes.
  - The first valid after a stall comes 2^WIDTH ticks later.
- Reset mid-window: the partial count is discarded; the first valid comes 2^WIDTH ticks after rst deasserts.
- Simultaneous tick and timeout: cannot occur, because tick clears to_cnt first.
- No output handshake: valid is a strobe and there is no back-pressure.

Optional Feature:
- Macro: PWM_IN_STABLE_EN.
- Defined:
  - A window result is committed to duty/valid only if it equals the previous window's raw result.
  - The raw result is stored in an extra WIDTH-bit register, cleared by rst and on stall.
  - Adds one window of latency after every duty change.
  - Suppresses the transient window that straddles a generator update.
- Undefined: every window end commits.

Decomposition:
- Shared package pwm_pkg:
  - PWM_WIDTH = 8.
  - Window length constant 2^PWM_WIDTH.
  - Default TIMEOUT.
  - Used by both pwm_out and pwm_in.
- One natural sub-module: pwm_sync, the parameterised SYNC_STAGES synchroniser plus rising-edge detector. Instantiated twice (edge output unused for pwm).

Test Plan:
- rst pulse mid-window, then pwm_out driving duty = 100 → no valid for 256 ticks after rst deasserts, then duty = 100 with a one-cycle valid every 256 ticks.
- Sweep duty 0..255 from pwm_out (update pulse, 100000 ns per step, pwm_clk 100 ns, clk 20 ns):
  - With the macro off: after each update, the second window reports the programmed value.
  - With PWM_IN_STABLE_EN: no intermediate (straddling) value is ever committed.
- pwm held at 1 for two windows → duty = 255 (saturated) with valid; pwm held at 0 → duty = 0.
- Stop pwm_clk for 100 clk cycles → stalled rises at cycle 64 and duty holds. Restart → stalled clears on the first tick and the next valid comes 256 ticks later with the correct value.
- Assert rst while stalled with duty = 37 → all outputs return to 0 in the next cycle.
